// File: rtl/keccak_perm_arbiter.sv
// Round-robin arbiter sharing one external Keccak-f[1600] round function between two requesters.
// Sequences ROUNDS iterations per permutation and returns the result tagged with the owner's ID.
//
// state | meaning
// IDLE  | waiting for a request; grant decoded combinationally from valids and rr
// RUN   | buffer replaced by round-function output each cycle, round index advancing
// DONE  | permuted state held on rsp_* until rsp_ready
module keccak_perm_arbiter #(
    parameter int ROUNDS = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [1599:0] req0_state,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [1599:0] req1_state,
    output logic          req1_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [1599:0] rsp_state,
    input  logic          rsp_ready,
    output logic [1599:0] f_state,
    output logic [4:0]    f_round,
    input  logic [1599:0] f_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t          state_q, state_d;
    logic [1599:0]   state_buf_q, state_buf_d;
    logic [4:0]      round_q, round_d;
    logic            id_q, id_d;
    logic            rr_q, rr_d;
    logic            idle;
    logic            grant0;
    logic            grant1;

    // A lone valid wins outright; on a tie rr picks the winner.
    always_comb begin
        idle   = (state_q == ST_IDLE);
        grant0 = idle & req0_valid & (~req1_valid | ~rr_q);
        grant1 = idle & req1_valid & (~req0_valid | rr_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        state_d     = state_q;
        state_buf_d = state_buf_q;
        round_d     = round_q;
        id_d        = id_q;
        rr_d        = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0) begin
                    state_buf_d = req0_state;
                    id_d        = 1'b0;
                    round_d     = 5'd0;
                    state_d     = ST_RUN;
                end else if (grant1) begin
                    state_buf_d = req1_state;
                    id_d        = 1'b1;
                    round_d     = 5'd0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                state_buf_d = f_out;
                if (round_q == LAST_ROUND) begin
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rr_d    = ~id_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            state_buf_q <= '0;
            round_q     <= 5'd0;
            id_q        <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            state_buf_q <= state_buf_d;
            round_q     <= round_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
        end
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_id    = id_q;
    assign rsp_state = state_buf_q;
    assign f_state   = state_buf_q;
    assign f_round   = round_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/keccak_perm_arbiter.md
# keccak_perm_arbiter

Shares a single combinational Keccak-f[1600] round datapath between two hash requesters, for example the PBKDF2 key-derivation engine and the message HMAC engine. The block accepts a 1600-bit state from one requester at a time, sequences `ROUNDS` round iterations through the external round function while driving the round index, and returns the permuted state tagged with the requester ID. Arbitration between the two requesters is round-robin. The block sits between the hash controllers and the shared round-function instance.

## Interface
- `ROUNDS`, 24: number of round iterations per permutation; legal range 1..32.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a state ready for permutation.
- `req0_state` in 1600: requester 0 input state; sampled only on transfer.
- `req0_ready` out 1: block accepts requester 0 this cycle.
- `req1_valid`, `req1_state`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid` out 1: a permuted state is available.
- `rsp_id` out 1: requester that owns the response (0 or 1).
- `rsp_state` out 1600: permuted state.
- `rsp_ready` in 1: consumer takes the response.
- `f_state` out 1600: state presented to the round function. Equals the internal buffer.
- `f_round` out 5: round index presented to the round function.
- `f_out` in 1600: combinational output of the round function for (`f_state`, `f_round`).
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- Internal registers: `buf[1599:0]`, `round[4:0]`, `id`, `rr` (the requester that wins a tie).
- IDLE:
  - Grant logic is combinational. If exactly one `reqN_valid` is high, that requester is granted. If both are high, requester `rr` is granted.
  - `reqN_ready` = 1 only for the granted requester, only in IDLE. The non-granted ready is 0.
  - Transfer occurs on `valid & ready`: `buf`←`reqN_state`, `id`←N, `round`←0, next state RUN.
- RUN, every cycle:
  - `buf`←`f_out`.
  - If `round == ROUNDS-1`, go to DONE. Otherwise `round`←`round+1`.
- DONE:
  - `rsp_valid` = 1, `rsp_state` = `buf`, `rsp_id` = `id`. All three are held stable until the handshake.
  - On `rsp_ready`: go to IDLE and set `rr`←`~id`, so the other requester wins the next tie.
  - No request is accepted in the same cycle as the `rsp_ready` handshake.
- `f_state` = `buf` and `f_round` = `round` in all states. The round function's output is used only in RUN.
- `rsp_ready` is ignored when the FSM is not in DONE. `reqN_valid` may drop before a grant with no side effects. Input state is captured only at transfer.
- `rsp_valid`, `rsp_id` and `rsp_state` are registered or decoded from the FSM state. Only `reqN_ready` is combinational from the `reqN_valid` inputs.

## Timing
- Reset values: state IDLE, `buf` = 0, `round` = 0, `id` = 0, `rr` = 0 (requester 0 wins the first tie).
- Output values in reset: `req0_ready`/`req1_ready` follow the grant logic in IDLE, so they are 0 unless the matching valid is high. `rsp_valid` = 0, `rsp_id` = 0, `rsp_state` = 0, `busy` = 0, `f_round` = 0, `f_state` = 0.
- Latency: with the transfer at edge T, RUN occupies cycles T+1 … T+ROUNDS, with `f_round` counting 0 … ROUNDS-1. `rsp_valid` rises in cycle T+ROUNDS+1, which is T+25 by default.
- Throughput: with `rsp_ready` tied high, one permutation every ROUNDS+2 cycles (26 by default).
- Reset mid-operation, in RUN or DONE: the block returns to the reset values on the next edge. No response is issued and the in-flight request is dropped. Requesters must reissue.
- Simultaneous events:
  - Both requesters valid in IDLE: exactly one ready, chosen by `rr`.
  - `rsp_ready` together with a new `reqN_valid` in DONE: the new request is accepted no earlier than the following cycle.

## Test plan
- Reset, then `req0_state` = 0 with `req0_valid` for one cycle: `req0_ready` = 1 in that cycle, and `f_round` steps 0..23 over 24 cycles. `rsp_valid` = 1 at cycle 25 with `rsp_id` = 0 and `rsp_state` lane[0,0] = 0xF1258F7940E1DDE7, the Keccak-f of the zero state. `rsp_ready` = 1 returns the FSM to IDLE.
- Both valids held high from reset with `rsp_ready` = 1: requester 0 is served first and requester 1 second. Grants alternate 0,1,0,1, with each grant 26 cycles apart.
- Back-pressure: hold `rsp_ready` = 0 for 10 cycles after `rsp_valid` rises. `rsp_state` and `rsp_id` stay stable, `busy` = 1, and both readies stay 0 throughout.
- Reset asserted at round 10 of a requester 1 job: on the next edge `busy` = 0, `rsp_valid` = 0 and `f_round` = 0. No response appears afterwards.
- Only requester 1 valid, with `rr` = 0: requester 1 is granted immediately with no wait for requester 0. `rsp_id` = 1.
- Requester 0 raises valid for one cycle while the block is busy, then drops it: no grant occurs and no response is generated for it.
